// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply / divide unit: 32 shift-add or restoring
// shift-subtract steps per operation, followed by a one-cycle DONE result pulse.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic                    ctrl_MULT,
  input  logic                    ctrl_DIV,
  output logic signed [WIDTH-1:0] data_result,
  output logic                    data_exception,
  output logic                    data_resultRDY,
  output logic                    busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] opa;
  logic [WIDTH-1:0]   opb;
  logic               neg_q;
  logic               div_zero;
  logic               div_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] q,
                                                input logic neg, input logic dz);
    if (dz) return '0;
    return neg ? -q : q;
  endfunction

  function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
  endfunction

  logic               last;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   quot_next;

  // The multiplier's sign bit carries weight -2^31, so its partial product is subtracted.
  always_comb begin
    last      = (cnt == 5'd31);
    addend    = '0;
    if (opb[0]) addend = last ? -opa : opa;
    prod_next = acc + addend;
    rem_sh    = {acc[WIDTH-1:0], opb[WIDTH-1]};
    diff      = rem_sh - {1'b0, opa[WIDTH-1:0]};
    q_bit     = ~diff[WIDTH];
    quot_next = {opb[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      opa            <= '0;
      opb            <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
          if (ctrl_MULT) begin
            opa   <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
            opb   <= data_operandB;
            state <= MUL;
          end else if (ctrl_DIV) begin
            opa      <= {{WIDTH{1'b0}}, mag(data_operandB)};
            opb      <= mag(data_operandA);
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
            state    <= DIV;
          end
        end
        MUL: begin
          acc <= prod_next;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 5'd1;
          if (last) begin
            data_result    <= prod_next[WIDTH-1:0];
            data_exception <= mul_ovf(prod_next);
            state          <= DONE;
          end
        end
        DIV: begin
          acc <= {{(WIDTH-1){1'b0}}, q_bit ? diff : rem_sh};
          opb <= quot_next;
          cnt <= cnt + 5'd1;
          if (last) begin
            data_result    <= fix_sign(quot_next, neg_q, div_zero);
            data_exception <= div_zero | div_ovf;
            state          <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);

endmodule
